// File: rtl/snn_sched_pkg.sv
// Shared definitions for the spiking-network timestep scheduler.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_GO     = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_RESULT = 3'd5,
    S_ERR    = 3'd6
  } sched_state_e;

  localparam int unsigned SCHED_T_W    = 8;
  localparam int unsigned SCHED_TO_CYC = 1024;

endpackage

// File: rtl/sched_wdog.sv
// Watchdog counter for the time spent waiting on net_done.
// clr_i zeroes the count, en_i advances it, expire_o flags the last allowed
// cycle (count == TO_CYC-1) while enabled.
module sched_wdog
  import snn_sched_pkg::*;
#(
  parameter int unsigned TO_CYC = SCHED_TO_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == CNT_W'(TO_CYC - 1));

  // Next count: clear wins, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snn_step_sched.sv
// Timestep scheduler: clears membrane state, then runs n_steps network
// timesteps (net_go / net_done), and returns a result via valid/ready.
// Optional watchdog on the net_done wait: define SNN_SCHED_WDOG_EN.
module snn_step_sched
  import snn_sched_pkg::*;
#(
  parameter int unsigned T_W    = SCHED_T_W,
  parameter int unsigned TO_CYC = SCHED_TO_CYC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [T_W-1:0] n_steps,
  output logic           mem_clr,
  output logic           net_go,
  input  logic           net_done,
  output logic [T_W-1:0] step_idx,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           err
);

  sched_state_e   state_q, state_d;
  logic [T_W-1:0] step_q, step_d;
  logic [T_W-1:0] nlat_q, nlat_d;
  logic           wdog_exp;

`ifdef SNN_SCHED_WDOG_EN
  sched_wdog #(
    .TO_CYC(TO_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == S_GO),
    .en_i    (state_q == S_WAIT),
    .expire_o(wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  // Sequencer next-state; net_done beats a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    nlat_d  = nlat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nlat_d  = n_steps;
          step_d  = '0;
          state_d = S_CLR;
        end
      end
      S_CLR:  state_d = (nlat_q == '0) ? S_RESULT : S_GO;
      S_GO:   state_d = S_WAIT;
      S_WAIT: begin
        if (net_done) begin
          state_d = (step_q == nlat_q - T_W'(1)) ? S_RESULT : S_NEXT;
        end else if (wdog_exp) begin
          state_d = S_ERR;
        end
      end
      S_NEXT: begin
        step_d  = step_q + T_W'(1);
        state_d = S_GO;
      end
      S_RESULT, S_ERR: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, step index and latched step count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      nlat_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      nlat_q  <= nlat_d;
    end
  end

  assign mem_clr   = (state_q == S_CLR);
  assign net_go    = (state_q == S_GO);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESULT) || (state_q == S_ERR);
  assign step_idx  = step_q;
`ifdef SNN_SCHED_WDOG_EN
  assign err       = (state_q == S_ERR);
`else
  assign err       = 1'b0;
`endif

endmodule
